// File: rtl/sar_afe_emu.sv
// Digital stand-in for the SAR ADC analog front end: track/hold, CDAC subtract and RTZ comparator.
// Optional compile macro SAR_EMU_DITHER_EN adds +1 LSB LFSR dither to the compare.
module sar_afe_emu #(
    parameter int          RESOLUTION = 8,
    parameter int          LATENCY    = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sample_i,
    input  logic [RESOLUTION-1:0] dac_p_i,
    input  logic [RESOLUTION-1:0] dac_n_i,
    input  logic [RESOLUTION-1:0] vin_p_i,
    input  logic [RESOLUTION-1:0] vin_n_i,
    output logic                  comp_p_o,
    output logic                  comp_n_o,
    output logic                  held_o,
    output logic [7:0]            cmp_count_o
);

    // state   | meaning
    // IDLE    | reset state, comparator quiet, waiting for first track request
    // TRACK   | input followed while sample_i is high, pipeline flushed
    // CONVERT | held input frozen, one decision evaluated per edge

    localparam int SW = RESOLUTION + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        CONVERT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  eval;
    logic                  d;
    logic [RESOLUTION-1:0] vin_p_h, vin_n_h;
    logic [LATENCY-1:0]    pipe_v, pipe_d;
    logic [LATENCY-1:0]    pipe_v_nxt, pipe_d_nxt;
    logic [7:0]            cnt_q;
    logic signed [SW-1:0]  vdiff, ddiff, vcmp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        eval    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_i) state_d = TRACK;
            end
            TRACK: begin
                if (!sample_i) begin
                    state_d = CONVERT;
                    eval    = 1'b1;
                end
            end
            CONVERT: begin
                if (sample_i) state_d = TRACK;
                else          eval    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any edge with sample_i high captures the input, so a one-cycle pulse out of IDLE still tracks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vin_p_h <= '0;
            vin_n_h <= '0;
        end else if (sample_i) begin
            vin_p_h <= vin_p_i;
            vin_n_h <= vin_n_i;
        end
    end

    assign vdiff = signed'({2'b00, vin_p_h}) - signed'({2'b00, vin_n_h});
    assign ddiff = signed'({2'b00, dac_p_i}) - signed'({2'b00, dac_n_i});

`ifdef SAR_EMU_DITHER_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     lfsr_q <= LFSR_SEED;
        else if (eval) lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end

    assign vcmp = vdiff + signed'({{(SW-1){1'b0}}, lfsr_q[0]});
`else
    assign vcmp = vdiff;
`endif

    assign d = (vcmp >= ddiff);

    always_comb begin
        pipe_v_nxt    = '0;
        pipe_d_nxt    = '0;
        pipe_v_nxt[0] = eval;
        pipe_d_nxt[0] = d;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_v_nxt[i] = pipe_v[i-1];
            pipe_d_nxt[i] = pipe_d[i-1];
        end
    end

    // A rising sample_i discards everything in flight so no stale decision reaches TRACK.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_v <= '0;
            pipe_d <= '0;
        end else if (sample_i) begin
            pipe_v <= '0;
            pipe_d <= '0;
        end else begin
            pipe_v <= pipe_v_nxt;
            pipe_d <= pipe_d_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                             cnt_q <= '0;
        else if (sample_i)                                     cnt_q <= '0;
        else if (pipe_v_nxt[LATENCY-1] && (cnt_q != 8'hFF))    cnt_q <= cnt_q + 8'd1;
    end

    assign comp_p_o    = pipe_v[LATENCY-1] &  pipe_d[LATENCY-1];
    assign comp_n_o    = pipe_v[LATENCY-1] & ~pipe_d[LATENCY-1];
    assign held_o      = (state_q == CONVERT);
    assign cmp_count_o = cnt_q;

endmodule

// File: tb/tb_sar_afe_emu.sv
// Directed bench for sar_afe_emu: three instances at LATENCY 1, 2 and 3 share one stimulus stream.
module tb_sar_afe_emu;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample;
    logic [7:0] dac_p, dac_n, vin_p, vin_n;

    logic       cp1, cn1, h1;
    logic       cp2, cn2, h2;
    logic       cp3, cn3, h3;
    logic [7:0] c1, c2, c3;

    int total = 0;
    int bad   = 0;

    logic [15:0] lf;
    logic        exp_d;

    always #5 clk = ~clk;

    sar_afe_emu #(.RESOLUTION(8), .LATENCY(1), .LFSR_SEED(16'hACE1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .sample_i(sample),
        .dac_p_i(dac_p), .dac_n_i(dac_n), .vin_p_i(vin_p), .vin_n_i(vin_n),
        .comp_p_o(cp1), .comp_n_o(cn1), .held_o(h1), .cmp_count_o(c1)
    );

    sar_afe_emu #(.RESOLUTION(8), .LATENCY(2), .LFSR_SEED(16'hACE1)) u_l2 (
        .clk_i(clk), .rst_i(rst), .sample_i(sample),
        .dac_p_i(dac_p), .dac_n_i(dac_n), .vin_p_i(vin_p), .vin_n_i(vin_n),
        .comp_p_o(cp2), .comp_n_o(cn2), .held_o(h2), .cmp_count_o(c2)
    );

    sar_afe_emu #(.RESOLUTION(8), .LATENCY(3), .LFSR_SEED(16'hACE1)) u_l3 (
        .clk_i(clk), .rst_i(rst), .sample_i(sample),
        .dac_p_i(dac_p), .dac_n_i(dac_n), .vin_p_i(vin_p), .vin_n_i(vin_n),
        .comp_p_o(cp3), .comp_n_o(cn3), .held_o(h3), .cmp_count_o(c3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        sample = 1'b0;
        dac_p  = 8'd0;
        dac_n  = 8'd0;
        vin_p  = 8'd200;
        vin_n  = 8'd56;
        #1;
        check("rst_cp1", cp1, 0);  check("rst_cn1", cn1, 0);
        check("rst_h1", h1, 0);    check("rst_c1", c1, 0);
        check("rst_cp3", cp3, 0);  check("rst_c3", c3, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_h1", h1, 0);

        // track 200/56 for two edges, then convert on LATENCY=1 instance
        sample = 1'b1;
        tick();
        check("trk_h1", h1, 0);  check("trk_cp1", cp1, 0);  check("trk_cn1", cn1, 0);
        tick();
        sample = 1'b0; dac_p = 8'd128; dac_n = 8'd128;
        tick();
        check("x128_cp", cp1, 1);  check("x128_cn", cn1, 0);
        check("x128_h", h1, 1);    check("x128_c", c1, 1);
        dac_p = 8'd255; dac_n = 8'd0;
        tick();
        check("x255_cp", cp1, 0);  check("x255_cn", cn1, 1);  check("x255_c", c1, 2);
        dac_p = 8'd200; dac_n = 8'd56;
        tick();
        check("tie_cp", cp1, 1);   check("tie_cn", cn1, 0);
        vin_p = 8'd0; dac_p = 8'd128; dac_n = 8'd128;
        tick();
        check("hold_cp", cp1, 1);  check("hold_h", h1, 1);
        dac_p = 8'd255; dac_n = 8'd0;
        tick();
        check("hold2_cn", cn1, 1); check("hold2_cp", cp1, 0);

        // retrack flushes; then eight convert edges alternating d=1 / d=0
        vin_p  = 8'd200;
        sample = 1'b1;
        tick();
        check("retrk_cp3", cp3, 0); check("retrk_cn3", cn3, 0);
        check("retrk_c3", c3, 0);   check("retrk_h3", h3, 0);
        sample = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 1) begin dac_p = 8'd128; dac_n = 8'd128; end
            else            begin dac_p = 8'd255; dac_n = 8'd0;   end
            tick();
            check("lat1_cp", cp1, (k % 2 == 1));
            check("lat1_cn", cn1, (k % 2 == 0));
            check("lat1_c", c1, k);
            check("lat2_cp", cp2, (k >= 2) && ((k - 1) % 2 == 1));
            check("lat2_cn", cn2, (k >= 2) && ((k - 1) % 2 == 0));
            check("lat2_c", c2, (k >= 2) ? k - 1 : 0);
            check("lat3_cp", cp3, (k >= 3) && ((k - 2) % 2 == 1));
            check("lat3_cn", cn3, (k >= 3) && ((k - 2) % 2 == 0));
            check("lat3_c", c3, (k >= 3) ? k - 2 : 0);
            check("lat3_h", h3, 1);
        end

        // abort with two decisions in flight on LATENCY=3
        sample = 1'b1;
        tick();
        check("abort_cp3", cp3, 0); check("abort_cn3", cn3, 0); check("abort_c3", c3, 0);
        check("abort_cp1", cp1, 0); check("abort_c1", c1, 0);
        tick();
        check("abort2_cp3", cp3, 0);
        sample = 1'b0; dac_p = 8'd255; dac_n = 8'd0;
        tick();
        check("stale1_cp3", cp3, 0); check("stale1_cn3", cn3, 0);
        tick();
        check("stale2_cp3", cp3, 0); check("stale2_cn3", cn3, 0); check("stale2_c3", c3, 0);
        tick();
        check("new_cn3", cn3, 1);    check("new_cp3", cp3, 0);   check("new_c3", c3, 1);
        check("pre_rst_cn2", cn2, 1);

        // asynchronous reset mid-conversion
        #1 rst = 1'b1;
        #1;
        check("arst_cp2", cp2, 0); check("arst_cn2", cn2, 0);
        check("arst_h2", h2, 0);   check("arst_c2", c2, 0);
        check("arst_cn3", cn3, 0); check("arst_h3", h3, 0);
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_cp2", cp2, 0); check("post_rst_cn2", cn2, 0);
            check("post_rst_h2", h2, 0);   check("post_rst_c2", c2, 0);
        end

        // vdiff = ddiff - 1: exact compare gives 0, dither follows lfsr[0]
        vin_p = 8'd100; vin_n = 8'd50; sample = 1'b1;
        tick();
        sample = 1'b0; dac_p = 8'd51; dac_n = 8'd0;
        lf = 16'hACE1;
        for (int k = 0; k < 64; k++) begin
            tick();
`ifdef SAR_EMU_DITHER_EN
            exp_d = lf[0];
`else
            exp_d = 1'b0;
`endif
            check("dith_cp", cp1, exp_d);
            check("dith_cn", cn1, !exp_d);
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end

        // single-cycle track pulse captures that cycle's vin
        vin_p = 8'd10; vin_n = 8'd20; sample = 1'b1;
        tick();
        sample = 1'b0; vin_p = 8'd200; vin_n = 8'd56; dac_p = 8'd0; dac_n = 8'd0;
        tick();
        check("pulse_cp1", cp1, 0); check("pulse_cn1", cn1, 1);
        check("pulse_c1", c1, 1);   check("pulse_h1", h1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
